// File: rtl/ld_imm_sequencer_if.sv
// ld_imm_sequencer_if: request/operand/write-strobe bundle for ld_imm_sequencer.
// slave modport = sequencer side; master modport = decoder/bus/register-file side.
// Inputs to sequencer: enable, ITABLE, data_in, data_valid.
// Outputs from sequencer: Pa_Ophd, PR_Write, PR_WriteSP, Mem_Write, PR_DataHi, PR_DataLo,
// P2_Set_CM1, busy, and timeout_err when LDIMM_TIMEOUT_EN is defined.
interface ld_imm_sequencer_if #(parameter int DATA_W = 8);
  logic enable;
  logic [7:0] ITABLE;
  logic [DATA_W-1:0] data_in;
  logic data_valid;
  logic Pa_Ophd;
  logic [7:0] PR_Write;
  logic PR_WriteSP;
  logic Mem_Write;
  logic [DATA_W-1:0] PR_DataHi;
  logic [DATA_W-1:0] PR_DataLo;
  logic P2_Set_CM1;
  logic busy;
`ifdef LDIMM_TIMEOUT_EN
  logic timeout_err;
`endif
  modport slave (
    input enable, ITABLE, data_in, data_valid,
    output Pa_Ophd, PR_Write, PR_WriteSP, Mem_Write, PR_DataHi, PR_DataLo, P2_Set_CM1, busy
`ifdef LDIMM_TIMEOUT_EN
    , output timeout_err
`endif
  );
  modport master (
    output enable, ITABLE, data_in, data_valid,
    input Pa_Ophd, PR_Write, PR_WriteSP, Mem_Write, PR_DataHi, PR_DataLo, P2_Set_CM1, busy
`ifdef LDIMM_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/ld_imm_sequencer.sv
// ld_imm_sequencer: multi-cycle LD r,n / LD rr,nn sequencer with operand fetch and one write strobe.
// Ports: CLK, RESET (async, active-high), bus (ld_imm_sequencer_if.slave).
// Optional macro LDIMM_TIMEOUT_EN: abort a FETCH state after TIMEOUT_CYCLES idle cycles and
// raise the sticky timeout_err output.
module ld_imm_sequencer #(
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic CLK,
  input logic RESET,
  ld_imm_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, WRITE} state_t;
`ifdef LDIMM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  logic r_terr;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  state_t r_state;
  logic [3:0] r_op;
  logic [DATA_W-1:0] r_lo;
  logic [7:0] r_wait;
  logic r_ophd, r_busy, r_wsp, r_mw, r_cm1;
  logic [7:0] r_pw;
  logic [DATA_W-1:0] r_hi_o, r_lo_o;
  logic w_tmo;
  // Abort on the cycle whose missing data_valid would bring the wait count to the limit.
  assign w_tmo = TMO_EN && !bus.data_valid && (r_wait == 8'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_op <= '0;
      r_lo <= '0;
      r_wait <= '0;
      r_ophd <= 1'b0;
      r_busy <= 1'b0;
      r_wsp <= 1'b0;
      r_mw <= 1'b0;
      r_cm1 <= 1'b0;
      r_pw <= '0;
      r_hi_o <= '0;
      r_lo_o <= '0;
`ifdef LDIMM_TIMEOUT_EN
      r_terr <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle: set only on the edge entering WRITE.
      r_pw <= '0;
      r_wsp <= 1'b0;
      r_mw <= 1'b0;
      r_cm1 <= 1'b0;
      case (r_state)
        IDLE: if (bus.enable && bus.ITABLE[7:4] == 4'h0) begin
          r_op <= bus.ITABLE[3:0];
          r_state <= FETCH_LO;
          r_ophd <= 1'b1;
          r_busy <= 1'b1;
          r_wait <= '0;
        end
        FETCH_LO: if (bus.data_valid) begin
          r_lo <= bus.data_in;
          r_wait <= '0;
          if (r_op[3]) r_state <= FETCH_HI;
          else begin
            r_state <= WRITE;
            r_ophd <= 1'b0;
            r_cm1 <= 1'b1;
            r_lo_o <= bus.data_in;
            if (r_op[2:0] == 3'd6) r_mw <= 1'b1;
            else begin
              r_pw <= 8'd1 << r_op[2:0];
              r_hi_o <= bus.data_in;
            end
          end
        end else if (w_tmo) begin
          r_state <= IDLE;
          r_ophd <= 1'b0;
          r_busy <= 1'b0;
`ifdef LDIMM_TIMEOUT_EN
          r_terr <= 1'b1;
`endif
        end else r_wait <= r_wait + 8'd1;
        FETCH_HI: if (bus.data_valid) begin
          r_state <= WRITE;
          r_ophd <= 1'b0;
          r_cm1 <= 1'b1;
          r_hi_o <= bus.data_in;
          r_lo_o <= r_lo;
          if (r_op[2:1] == 2'd3) r_wsp <= 1'b1;
          else r_pw <= 8'b11 << {r_op[2:1], 1'b0};
        end else if (w_tmo) begin
          r_state <= IDLE;
          r_ophd <= 1'b0;
          r_busy <= 1'b0;
`ifdef LDIMM_TIMEOUT_EN
          r_terr <= 1'b1;
`endif
        end else r_wait <= r_wait + 8'd1;
        default: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end
  assign bus.Pa_Ophd = r_ophd;
  assign bus.busy = r_busy;
  assign bus.PR_Write = r_pw;
  assign bus.PR_WriteSP = r_wsp;
  assign bus.Mem_Write = r_mw;
  assign bus.P2_Set_CM1 = r_cm1;
  assign bus.PR_DataHi = r_hi_o;
  assign bus.PR_DataLo = r_lo_o;
`ifdef LDIMM_TIMEOUT_EN
  assign bus.timeout_err = r_terr;
`endif
endmodule

// File: tb/tb_ld_imm_sequencer.sv
// tb_ld_imm_sequencer: directed self-checking bench for ld_imm_sequencer.
module tb_ld_imm_sequencer;
  logic CLK = 1'b0;
  logic RESET;
  int checks = 0;
  int errors = 0;
  ld_imm_sequencer_if #(.DATA_W(8)) bus ();
  ld_imm_sequencer #(.DATA_W(8), .TIMEOUT_CYCLES(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    RESET = 1'b1;
    bus.enable = 1'b0;
    bus.ITABLE = 8'h00;
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.Pa_Ophd, bus.PR_WriteSP, bus.Mem_Write, bus.P2_Set_CM1} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 00000", {bus.busy, bus.Pa_Ophd, bus.PR_WriteSP, bus.Mem_Write, bus.P2_Set_CM1});
    end
    checks++;
    if ({bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 000000", {bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo});
    end
    RESET = 1'b0;
    tick();
  endtask
  task automatic test_ld_e;
    bus.ITABLE = 8'h03;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h5A;
    checks++;
    if (bus.Pa_Ophd !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL lde_fetch got ophd=%b busy=%b exp 1 1", bus.Pa_Ophd, bus.busy);
    end
    tick();
    bus.data_valid = 1'b0;
    checks++;
    if ({bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1, bus.Mem_Write, bus.PR_WriteSP} !== {8'h08, 8'h5A, 8'h5A, 3'b100}) begin
      errors++;
      $display("FAIL lde_write got pw=%h hi=%h lo=%h cm1=%b mw=%b sp=%b exp 08 5a 5a 1 0 0",
               bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1, bus.Mem_Write, bus.PR_WriteSP);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.PR_Write !== 8'h00 || bus.P2_Set_CM1 !== 1'b0) begin
      errors++;
      $display("FAIL lde_done got busy=%b pw=%h cm1=%b exp 0 00 0", bus.busy, bus.PR_Write, bus.P2_Set_CM1);
    end
  endtask
  task automatic test_ld_hl;
    int ophd = 0;
    int writes = 0;
    bus.ITABLE = 8'h0C;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      bus.data_valid = (c == 1 || c == 3);
      bus.data_in = (c == 1) ? 8'h34 : (c == 3) ? 8'h12 : 8'hFF;
      ophd += int'(bus.Pa_Ophd);
      if (bus.PR_Write != 8'h00) writes++;
      if (c == 4) begin
        checks++;
        if ({bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1} !== {8'h30, 8'h12, 8'h34, 1'b1}) begin
          errors++;
          $display("FAIL hl_write got pw=%h hi=%h lo=%h cm1=%b exp 30 12 34 1", bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1);
        end
      end
      tick();
    end
    bus.data_valid = 1'b0;
    checks++;
    if (ophd !== 3) begin
      errors++;
      $display("FAIL hl_ophd_cycles got %0d exp 3", ophd);
    end
    checks++;
    if (writes !== 1) begin
      errors++;
      $display("FAIL hl_write_cycles got %0d exp 1", writes);
    end
    checks++;
    if (bus.PR_DataHi !== 8'h12 || bus.PR_DataLo !== 8'h34 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hl_hold got hi=%h lo=%h busy=%b exp 12 34 0", bus.PR_DataHi, bus.PR_DataLo, bus.busy);
    end
  endtask
  task automatic test_mem_sp;
    logic [7:0] pw_or = 8'h00;
    int mw = 0;
    int sp = 0;
    bus.ITABLE = 8'h06;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h77;
    tick();
    bus.data_valid = 1'b0;
    pw_or |= bus.PR_Write;
    checks++;
    if ({bus.Mem_Write, bus.PR_WriteSP, bus.P2_Set_CM1, bus.PR_DataLo, bus.PR_DataHi} !== {3'b101, 8'h77, 8'h12}) begin
      errors++;
      $display("FAIL mem_write got mw=%b sp=%b cm1=%b lo=%h hi=%h exp 1 0 1 77 12",
               bus.Mem_Write, bus.PR_WriteSP, bus.P2_Set_CM1, bus.PR_DataLo, bus.PR_DataHi);
    end
    tick();
    bus.ITABLE = 8'h0E;
    bus.enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      bus.enable = 1'b0;
      bus.data_valid = (c < 2);
      bus.data_in = (c == 0) ? 8'hCD : 8'hAB;
      pw_or |= bus.PR_Write;
      mw += int'(bus.Mem_Write);
      sp += int'(bus.PR_WriteSP);
      if (bus.PR_WriteSP === 1'b1) begin
        checks++;
        if (bus.PR_DataHi !== 8'hAB || bus.PR_DataLo !== 8'hCD || bus.P2_Set_CM1 !== 1'b1) begin
          errors++;
          $display("FAIL sp_data got hi=%h lo=%h cm1=%b exp ab cd 1", bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1);
        end
      end
    end
    bus.data_valid = 1'b0;
    checks++;
    if (pw_or !== 8'h00 || mw !== 0 || sp !== 1) begin
      errors++;
      $display("FAIL sp_strobes got pw_or=%h mw=%0d sp=%0d exp 00 0 1", pw_or, mw, sp);
    end
  endtask
  task automatic test_ignore;
    int writes = 0;
    bus.ITABLE = 8'h13;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.Pa_Ophd !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode got busy=%b ophd=%b exp 0 0", bus.busy, bus.Pa_Ophd);
    end
    bus.data_valid = 1'b1;
    bus.data_in = 8'hEE;
    tick();
    tick();
    bus.data_valid = 1'b0;
    checks++;
    if (bus.PR_DataLo !== 8'hCD || bus.PR_DataHi !== 8'hAB || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got lo=%h hi=%h busy=%b exp cd ab 0", bus.PR_DataLo, bus.PR_DataHi, bus.busy);
    end
    bus.ITABLE = 8'h01;
    bus.enable = 1'b1;
    tick();
    bus.data_valid = 1'b1;
    bus.data_in = 8'h11;
    tick();
    bus.data_valid = 1'b0;
    checks++;
    if (bus.PR_Write !== 8'h02 || bus.PR_DataLo !== 8'h11) begin
      errors++;
      $display("FAIL busy_enable_write got pw=%h lo=%h exp 02 11", bus.PR_Write, bus.PR_DataLo);
    end
    tick();
    bus.enable = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_in_write got busy=%b exp 0", bus.busy);
    end
    for (int c = 0; c < 4; c++) begin
      if (bus.PR_Write != 8'h00 || bus.P2_Set_CM1) writes++;
      tick();
    end
    checks++;
    if (writes !== 0) begin
      errors++;
      $display("FAIL no_second_write got %0d exp 0", writes);
    end
  endtask
  task automatic test_back_to_back;
    bus.ITABLE = 8'h00;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h21;
    tick();
    bus.data_valid = 1'b0;
    checks++;
    if (bus.PR_Write !== 8'h01 || bus.PR_DataHi !== 8'h21) begin
      errors++;
      $display("FAIL b2b_first got pw=%h hi=%h exp 01 21", bus.PR_Write, bus.PR_DataHi);
    end
    tick();
    bus.ITABLE = 8'h02;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    checks++;
    if (bus.Pa_Ophd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got ophd=%b exp 1", bus.Pa_Ophd);
    end
    bus.data_valid = 1'b1;
    bus.data_in = 8'h43;
    tick();
    bus.data_valid = 1'b0;
    checks++;
    if (bus.PR_Write !== 8'h04 || bus.PR_DataLo !== 8'h43) begin
      errors++;
      $display("FAIL b2b_second got pw=%h lo=%h exp 04 43", bus.PR_Write, bus.PR_DataLo);
    end
    tick();
  endtask
  task automatic test_reset_mid;
    int strobes = 0;
    bus.ITABLE = 8'h0C;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h55;
    tick();
    bus.data_valid = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.Pa_Ophd, bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo} !== 26'h0) begin
      errors++;
      $display("FAIL async_reset got busy=%b ophd=%b pw=%h hi=%h lo=%h exp all 0", bus.busy, bus.Pa_Ophd, bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo);
    end
    #1;
    RESET = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h66;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.PR_Write != 8'h00 || bus.Mem_Write || bus.PR_WriteSP || bus.P2_Set_CM1) strobes++;
    end
    bus.data_valid = 1'b0;
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL post_reset_strobes got %0d exp 0", strobes);
    end
    bus.ITABLE = 8'h07;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h99;
    tick();
    bus.data_valid = 1'b0;
    checks++;
    if ({bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1} !== {8'h80, 8'h99, 8'h99, 1'b1}) begin
      errors++;
      $display("FAIL ld_a got pw=%h hi=%h lo=%h cm1=%b exp 80 99 99 1", bus.PR_Write, bus.PR_DataHi, bus.PR_DataLo, bus.P2_Set_CM1);
    end
    tick();
  endtask
`ifdef LDIMM_TIMEOUT_EN
  task automatic test_timeout;
    int ophd = 0;
    int strobes = 0;
    bus.ITABLE = 8'h01;
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      ophd += int'(bus.Pa_Ophd);
      if (bus.PR_Write != 8'h00 || bus.P2_Set_CM1) strobes++;
      tick();
    end
    checks++;
    if (ophd !== 4 || strobes !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort got ophd=%0d strobes=%0d busy=%b exp 4 0 0", ophd, strobes, bus.busy);
    end
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got %b exp 1", bus.timeout_err);
    end
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b exp 0", bus.timeout_err);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_ld_e();
    test_ld_hl();
    test_mem_sp();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef LDIMM_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
